// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
// Gray output is enabled with UPDOWN_MOD_COUNTER_GRAY_EN.
package updown_mod_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic [31:0] gray_enc(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic bit params_ok(input int width, input int mod, input int rv);
    longint span;
    span = longint'(1) << width;
    return (width >= 1) && (mod >= 2) && (longint'(mod) <= span)
      && (rv >= 0) && (rv < mod);
  endfunction

endpackage

// File: rtl/updown_mod_next.sv
// Next-state logic for the modulo-N counter: load, step, wrap and saturate.
// Arithmetic is one bit wider than the count so MOD = 2**WIDTH cannot alias.
module updown_mod_next
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int MOD   = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap,
  output logic             next_sat
);

  localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MOD - 1);

  logic [WIDTH:0] c;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic [WIDTH:0] lv;
  logic           top;
  logic           bot;

  assign c   = {1'b0, count};
  assign inc = c + 1'b1;
  assign dec = c - 1'b1;
  assign lv  = {1'b0, load_val};
  assign top = (c == MAXV);
  assign bot = (c == '0);

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    next_sat   = 1'b0;
    unique case (1'b1)
      load: begin
        next_count = (lv < MODV) ? load_val : MAXV[WIDTH-1:0];
      end
      (!load && en && up): begin
        if (!top) begin
          next_count = inc[WIDTH-1:0];
        end else if (sat_mode == MODE_WRAP) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end else begin
          next_sat = 1'b1;
        end
      end
      (!load && en && !up): begin
        if (!bot) begin
          next_count = dec[WIDTH-1:0];
        end else if (sat_mode == MODE_WRAP) begin
          next_count = MAXV[WIDTH-1:0];
          next_wrap  = 1'b1;
        end else begin
          next_sat = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with load, wrap/saturate mode and event flags.
// Define UPDOWN_MOD_COUNTER_GRAY_EN to add the registered count_gray output.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MOD       = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  if (!params_ok(WIDTH, MOD, RESET_VAL)) begin : g_bad_params
    $error("updown_mod_counter: illegal WIDTH/MOD/RESET_VAL");
  end

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             next_sat;

  updown_mod_next #(
    .WIDTH(WIDTH),
    .MOD  (MOD)
  ) u_next (
    .count     (count),
    .up        (up),
    .sat_mode  (sat_mode),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .next_count(next_count),
    .next_wrap (next_wrap),
    .next_sat  (next_sat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= RV;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
      sat   <= next_sat;
    end
  end

`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_gray <= WIDTH'(gray_enc(32'(RV)));
    end else begin
      count_gray <= WIDTH'(gray_enc(32'(next_count)));
    end
  end
`endif

  assign at_max = (count == MAX);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench: three counter configurations driven together, checked every cycle
// against an integer model plus hand-computed directed expectations.
module tb_updown_mod_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       sm = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [1:0] c4;
  logic       w4, s4, mx4, mn4;
  logic [3:0] c10;
  logic       w10, s10, mx10, mn10;
  logic [3:0] c16;
  logic       w16, s16, mx16, mn16;
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
  logic [1:0] g4;
  logic [3:0] g10, g16;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  updown_mod_counter #(.WIDTH(2), .MOD(4), .RESET_VAL(0)) d4 (
    .clock(clock), .reset(reset), .en(en), .up(up), .sat_mode(sm),
    .load(ld), .load_val(lv[1:0]), .count(c4), .wrap(w4), .sat(s4),
    .at_max(mx4), .at_min(mn4)
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    , .count_gray(g4)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(5)) d10 (
    .clock(clock), .reset(reset), .en(en), .up(up), .sat_mode(sm),
    .load(ld), .load_val(lv), .count(c10), .wrap(w10), .sat(s10),
    .at_max(mx10), .at_min(mn10)
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    , .count_gray(g10)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MOD(16), .RESET_VAL(0)) d16 (
    .clock(clock), .reset(reset), .en(en), .up(up), .sat_mode(sm),
    .load(ld), .load_val(lv), .count(c16), .wrap(w16), .sat(s16),
    .at_max(mx16), .at_min(mn16)
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    , .count_gray(g16)
`endif
  );

  // Integer model of one counter step.
  function automatic void mstep(
    input int c, input int mod, input bit e, input bit u, input bit s,
    input bit l, input int v, output int nc, output bit nw, output bit ns);
    nc = c;
    nw = 1'b0;
    ns = 1'b0;
    if (l) begin
      nc = (v < mod) ? v : mod - 1;
    end else if (e && u) begin
      if (c < mod - 1) nc = c + 1;
      else if (s) ns = 1'b1;
      else begin nc = 0; nw = 1'b1; end
    end else if (e) begin
      if (c > 0) nc = c - 1;
      else if (s) ns = 1'b1;
      else begin nc = mod - 1; nw = 1'b1; end
    end
  endfunction

  int m4, m10, m16;
  bit mw4, mw10, mw16, ms4, ms10, ms16;

  always @(posedge clock or negedge reset) begin
    int n4, n10, n16;
    bit a4, a10, a16, b4, b10, b16;
    if (!reset) begin
      m4 <= 0; m10 <= 5; m16 <= 0;
      mw4 <= 0; mw10 <= 0; mw16 <= 0;
      ms4 <= 0; ms10 <= 0; ms16 <= 0;
    end else begin
      mstep(m4, 4, en, up, sm, ld, int'(lv[1:0]), n4, a4, b4);
      mstep(m10, 10, en, up, sm, ld, int'(lv), n10, a10, b10);
      mstep(m16, 16, en, up, sm, ld, int'(lv), n16, a16, b16);
      m4 <= n4; m10 <= n10; m16 <= n16;
      mw4 <= a4; mw10 <= a10; mw16 <= a16;
      ms4 <= b4; ms10 <= b10; ms16 <= b16;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("m4.count", 32'(c4), m4);
    chk("m4.wrap", 32'(w4), 32'(mw4));
    chk("m4.sat", 32'(s4), 32'(ms4));
    chk("m4.at_max", 32'(mx4), 32'(m4 == 3));
    chk("m4.at_min", 32'(mn4), 32'(m4 == 0));
    chk("m10.count", 32'(c10), m10);
    chk("m10.wrap", 32'(w10), 32'(mw10));
    chk("m10.sat", 32'(s10), 32'(ms10));
    chk("m10.at_max", 32'(mx10), 32'(m10 == 9));
    chk("m10.at_min", 32'(mn10), 32'(m10 == 0));
    chk("m16.count", 32'(c16), m16);
    chk("m16.wrap", 32'(w16), 32'(mw16));
    chk("m16.sat", 32'(s16), 32'(ms16));
    chk("m16.at_max", 32'(mx16), 32'(m16 == 15));
    chk("m16.at_min", 32'(mn16), 32'(m16 == 0));
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    chk("m4.gray", 32'(g4), 32'(m4 ^ (m4 >> 1)));
    chk("m10.gray", 32'(g10), 32'(m10 ^ (m10 >> 1)));
    chk("m16.gray", 32'(g16), 32'(m16 ^ (m16 >> 1)));
`endif
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int ea[5] = '{1, 2, 3, 0, 1};
    int wa[5] = '{0, 0, 0, 1, 0};
    int eb[3] = '{0, 3, 2};
    int wb[3] = '{0, 1, 0};
    int sc[3] = '{0, 1, 1};

    tick();
    tick();
    chk("rst d4.count", 32'(c4), 0);
    chk("rst d10.count", 32'(c10), 5);
    chk("rst d10.flags", 32'({w10, s10}), 0);
    chk("rst d4.at_min", 32'(mn4), 1);
    reset = 1'b1;

    // wrap sequence at modulus 4, up then down
    en = 1'b1; up = 1'b1; sm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("A d4.count", 32'(c4), 32'(ea[i]));
      chk("A d4.wrap", 32'(w4), 32'(wa[i]));
    end
    chk("A d10.count", 32'(c10), 0);
    chk("A d10.wrap", 32'(w10), 1);
    chk("A d16.count", 32'(c16), 5);
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("B d4.count", 32'(c4), 32'(eb[i]));
      chk("B d4.wrap", 32'(w4), 32'(wb[i]));
    end

    // saturation after load at modulus 10
    ld = 1'b1; lv = 4'd8; sm = 1'b1; en = 1'b0;
    tick();
    chk("C d10.load", 32'(c10), 8);
    chk("C d10.sat", 32'(s10), 0);
    chk("C d4.load", 32'(c4), 0);
    ld = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("C d10.count", 32'(c10), 9);
      chk("C d10.sat", 32'(s10), 32'(sc[i]));
      chk("C d10.at_max", 32'(mx10), 1);
    end
    chk("C d16.count", 32'(c16), 11);
    up = 1'b0;
    tick();
    chk("C d10.down", 32'(c10), 8);
    chk("C d10.sat0", 32'(s10), 0);

    // clamped load beats enabled step
    ld = 1'b1; lv = 4'd13; en = 1'b1; up = 1'b0;
    tick();
    chk("D d10.clamp", 32'(c10), 9);
    chk("D d16.load", 32'(c16), 13);
    chk("D d4.load", 32'(c4), 1);

    // full-range wrap at MOD=16
    lv = 4'd15; sm = 1'b0;
    tick();
    chk("E d16.load", 32'(c16), 15);
    ld = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("E d16.count", 32'(c16), 0);
    chk("E d16.wrap", 32'(w16), 1);
    chk("E d10.wrap", 32'(w10), 1);
    en = 1'b0;
    tick();
    tick();
    chk("E d16.hold", 32'(c16), 0);
    chk("E d16.wrap0", 32'(w16), 0);

    // async reset mid-cycle with a wrap flag pending
    en = 1'b1; up = 1'b0;
    tick();
    chk("F d10.count", 32'(c10), 9);
    chk("F d10.wrap", 32'(w10), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("F d10.async", 32'(c10), 5);
    chk("F d10.wrapclr", 32'(w10), 0);
    chk("F d16.async", 32'(c16), 0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    up = 1'b1;
    tick();
    chk("F d10.resume", 32'(c10), 6);
    tick();
    chk("F d10.next", 32'(c10), 7);

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised modulo-N up/down counter FSM, successor to the fixed 2-bit wrap counter.
- Adds:
  - configurable modulus and width
  - count enable
  - synchronous parallel load
  - run-time wrap/saturate mode
  - registered wrap/saturation event flags
- Used as a direction-controlled position/index counter in control paths.
- With MOD=4, mode=wrap and en tied high, the count sequence is 0→1→2→3→0 (up) and 0→3→2→1→0 (down), exactly as the 2-bit predecessor.

Parameters:
- WIDTH, 2, counter width in bits. Must be ≥1.
- MOD, 4, modulus; count range 0..MOD-1. Must satisfy 2 ≤ MOD ≤ 2**WIDTH.
- RESET_VAL, 0, count value on reset. Must be < MOD.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable; no step when low
- up  in  1  direction: 1 = increment, 0 = decrement
- sat_mode  in  1  0 = wrap at bounds, 1 = saturate at bounds
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count (registered)
- wrap  out  1  registered pulse: a wrap occurred on the last edge
- sat  out  1  registered: last enabled step was blocked by saturation
- at_max  out  1  combinational: count == MOD-1
- at_min  out  1  combinational: count == 0

Behaviour:
- Reset: the decided reset is reset, asynchronous, active-low; clock is clock. While reset is low: count=RESET_VAL, wrap=0, sat=0, independent of clock. The first edge after release behaves normally.
- Priority on each rising edge: load > en > hold.
- Load:
  - count ← load_val if load_val < MOD, else count ← MOD-1 (clamp).
  - wrap ← 0, sat ← 0.
  - en and up are ignored in that cycle.
- Enabled step, wrap mode (sat_mode=0):
  - up=1: count ← count+1. If count == MOD-1, count ← 0 and wrap ← 1.
  - up=0: count ← count-1. If count == 0, count ← MOD-1 and wrap ← 1.
  - sat ← 0.
- Enabled step, saturate mode (sat_mode=1):
  - up=1 at MOD-1, or up=0 at 0: count holds, sat ← 1, wrap ← 0.
  - Otherwise: normal ±1, sat ← 0, wrap ← 0.
- Hold (en=0, load=0): count holds; wrap ← 0; sat ← 0.
- Flag timing:
  - wrap and sat are single-cycle pulses, valid in the same cycle as the updated count.
  - In saturate mode with en held at a bound, sat stays high every cycle.
- Latency: one clock from en/load to the new count. at_max and at_min have zero latency relative to count.
- Width rules:
  - Next-state arithmetic is done at WIDTH+1 bits, so MOD = 2**WIDTH wraps correctly with no overflow aliasing.
  - The count register never holds a value ≥ MOD under any input sequence.
- Mid-operation changes:
  - A sat_mode or up change takes effect on the next edge. No pipeline state is kept.
- Reset asserted mid-count: immediate return to RESET_VAL; pending flags are cleared.

Optional Feature:
- Macro: UPDOWN_MOD_COUNTER_GRAY_EN.
- Defined:
  - Adds output port count_gray [WIDTH-1:0], registered, equal to binary-to-Gray(count) in the same cycle as count.
  - Reset value is Gray(RESET_VAL).
  - Only meaningful for clock-domain crossing when MOD = 2**WIDTH; this is a documented usage restriction, not checked in RTL.
- Undefined: port count_gray and its register are absent. All other behaviour is identical.

Decomposition:
- Package updown_mod_counter_pkg:
  - mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1
  - function gray_enc(bin)
  - parameter-check helper (MOD range, RESET_VAL < MOD)
- Sub-module updown_mod_next (purely combinational):
  - Inputs: count, up, sat_mode, en, load, load_val.
  - Outputs: next_count, next_wrap, next_sat.
  - Parameterised by WIDTH and MOD. The top level holds only registers and the at_max/at_min decode.

Test Plan:
- MOD=4, WIDTH=2, sat_mode=0, en=1, up=1 for 5 edges → count 1,2,3,0,1; wrap=1 only in the cycle count=0. Then up=0 → 0,3,2 with wrap=1 at 3.
- MOD=10, WIDTH=4, sat_mode=1, load=1 with load_val=8, then up=1 for 3 edges → count 8,9,9,9; sat=0,0,1,1; at_max=1 from count=9. Then up=0 → count 8, sat=0.
- MOD=10, load_val=13 → count=9 (clamped). Same cycle with en=1, up=0 → load wins, count=9.
- MOD=16, WIDTH=4, count=15, up=1, wrap mode → count=0, wrap=1 (full-range wrap, no aliasing). en=0 for 2 cycles → count holds at 0, wrap=0.
- RESET_VAL=5, MOD=10: assert reset asynchronously mid-cycle while counting → count=5 immediately, before the next edge; flags 0. Release → counting resumes from 5 on the next enabled edge.
- With UPDOWN_MOD_COUNTER_GRAY_EN, MOD=8, WIDTH=3, count up 0..7..0 → count_gray 000,001,011,010,110,111,101,100,000; exactly one bit changes per step.
